// File: rtl/ldpc_dvb_dec_source_pkg.sv
// Shared constants for the LDPC DVB-S2 decoder source (input side):
// column/size type, pack ratio helper and the source FSM state encoding.
package ldpc_dvb_dec_source_pkg;

  localparam int cWADDR_W = 8;
  localparam int cWDAT_W  = 8;
  localparam int cDAT_W   = 2;

  // Frame size / column index type; the integration binds iwsize from this.
  typedef logic [cWADDR_W-1:0] col_t;

  // Number of stream words packed into one memory word.
  function automatic int pack_ratio(input int wdat_w, input int dat_w);
    return wdat_w / dat_w;
  endfunction

  localparam int pPACK = pack_ratio(cWDAT_W, cDAT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_DONE = 2'd2,
    ST_DROP = 2'd3
  } src_state_t;

endpackage

// File: rtl/ldpc_dvb_dec_source_pack.sv
// Packer for the decoder source: collects stream words LSB-first into one
// memory word, zero-pads a partial word on flush and issues the write strobe.
module ldpc_dvb_dec_source_pack
  import ldpc_dvb_dec_source_pkg::*;
#(
  parameter int pWADDR_W = 8,
  parameter int pWDAT_W  = 8,
  parameter int pDAT_W   = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clkena_i,
  input  logic                push_i,
  input  logic                restart_i,
  input  logic                flush_i,
  input  logic [pDAT_W-1:0]   dat_i,
  input  logic [pWADDR_W-1:0] addr_i,
  output logic                pack_done_o,
  output logic                write_o,
  output logic [pWADDR_W-1:0] waddr_o,
  output logic [pWDAT_W-1:0]  wdat_o
);

  localparam int cPACK  = pack_ratio(pWDAT_W, pDAT_W);
  localparam int cCNT_W = (cPACK > 1) ? $clog2(cPACK) : 1;
  localparam logic [cCNT_W-1:0] cLAST = cCNT_W'(cPACK - 1);
  localparam logic [cCNT_W-1:0] cONE  = cCNT_W'(1);

  logic [cCNT_W-1:0]   cnt_q, cnt_d, cnt_eff_s;
  logic [pWDAT_W-1:0]  sreg_q, sreg_d, base_s, word_s;
  logic                write_q, write_d;
  logic [pWADDR_W-1:0] waddr_q, waddr_d;
  logic [pWDAT_W-1:0]  wdat_q, wdat_d;

  // A restart discards whatever partial word was being collected.
  assign cnt_eff_s   = restart_i ? {cCNT_W{1'b0}} : cnt_q;
  assign base_s      = restart_i ? {pWDAT_W{1'b0}} : sreg_q;
  assign pack_done_o = (cnt_eff_s == cLAST);

  // Place the incoming word into its slot; untouched slots keep their contents.
  always_comb begin
    word_s = base_s;
    for (int k = 0; k < cPACK; k++) begin
      word_s[k*pDAT_W +: pDAT_W] = (cnt_eff_s == cCNT_W'(k)) ? dat_i
                                                             : base_s[k*pDAT_W +: pDAT_W];
    end
  end

  // Next-state of the collector and of the registered write port.
  always_comb begin
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdat_d  = wdat_q;
    if (push_i) begin
      if (pack_done_o | flush_i) begin
        write_d = 1'b1;
        waddr_d = addr_i;
        wdat_d  = word_s;
        cnt_d   = {cCNT_W{1'b0}};
        sreg_d  = {pWDAT_W{1'b0}};
      end else begin
        cnt_d   = cnt_eff_s + cONE;
        sreg_d  = word_s;
      end
    end else begin
      cnt_d  = cnt_q;
      sreg_d = sreg_q;
    end
  end

  // Collector and write-port registers; everything holds while clkena_i is low.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= {cCNT_W{1'b0}};
      sreg_q  <= {pWDAT_W{1'b0}};
      write_q <= 1'b0;
      waddr_q <= {pWADDR_W{1'b0}};
      wdat_q  <= {pWDAT_W{1'b0}};
    end else if (clkena_i) begin
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdat_q  <= wdat_d;
    end
  end

  assign write_o = write_q;
  assign waddr_o = waddr_q;
  assign wdat_o  = wdat_q;

endmodule

// File: rtl/ldpc_dvb_dec_source.sv
// LDPC DVB-S2 decoder source: accepts a framed LLR stream, writes the frame
// into the free half of a ping-pong input buffer and strobes "buffer full"
// with the frame tag. Framing errors are reported on a one-cycle oerr strobe.
module ldpc_dvb_dec_source
  import ldpc_dvb_dec_source_pkg::*;
#(
  parameter int pWADDR_W = 8,
  parameter int pWDAT_W  = 8,
  parameter int pDAT_W   = 2,
  parameter int pTAG_W   = 4
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic [pWADDR_W-1:0] iwsize,
  input  logic                isop,
  input  logic                ieop,
  input  logic                ival,
  input  logic [pDAT_W-1:0]   idat,
  input  logic [pTAG_W-1:0]   itag,
  output logic                ordy,
  input  logic                iwempty,
  output logic                owrite,
  output logic [pWADDR_W-1:0] owaddr,
  output logic [pWDAT_W-1:0]  owdat,
  output logic [pTAG_W-1:0]   owtag,
  output logic                owfull,
  output logic                oerr
);

  localparam logic [pWADDR_W-1:0] cADDR_ZERO = {pWADDR_W{1'b0}};
  localparam logic [pWADDR_W-1:0] cADDR_ONE  = pWADDR_W'(1);

  src_state_t          state_q, state_d;
  logic [pWADDR_W-1:0] size_q, size_d, addr_q, addr_d;
  logic [pTAG_W-1:0]   tag_q, tag_d, owtag_q, owtag_d;
  logic                err_q, err_d, drop_q, drop_d;
  logic                owfull_q, owfull_d, oerr_q, oerr_d;

  logic                ordy_s, acc_s, start_s, cont_s, push_s, flush_s;
  logic                pack_done_s, is_last_s;
  logic [pWADDR_W-1:0] size_eff_s, addr_eff_s;

  // Ready only in word-taking states, with a free buffer half and no pending swap.
  assign ordy_s = iwempty & ~owfull_q &
                  ((state_q == ST_IDLE) | (state_q == ST_WR) | (state_q == ST_DROP));
  assign ordy   = ordy_s;
  assign acc_s  = ival & ordy_s & iclkena;

  // Classify an accepted word: frame start (any sop) or frame continuation.
  always_comb begin
    start_s = 1'b0;
    cont_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DROP: begin
        start_s = acc_s & isop;
        cont_s  = 1'b0;
      end
      ST_WR: begin
        start_s = acc_s & isop;
        cont_s  = acc_s & ~isop;
      end
      default: begin
        start_s = 1'b0;
        cont_s  = 1'b0;
      end
    endcase
  end

  // A starting word uses the freshly presented size and address 0.
  assign push_s     = start_s | cont_s;
  assign size_eff_s = start_s ? iwsize : size_q;
  assign addr_eff_s = start_s ? cADDR_ZERO : addr_q;
  assign is_last_s  = pack_done_s & (addr_eff_s == (size_eff_s - cADDR_ONE));
  assign flush_s    = push_s & ieop & ~is_last_s;

  // Frame FSM: next state, latched frame attributes and the owfull/oerr strobes.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    tag_d    = tag_q;
    addr_d   = addr_q;
    err_d    = err_q;
    drop_d   = drop_q;
    owfull_d = 1'b0;
    oerr_d   = 1'b0;
    owtag_d  = owtag_q;
    case (state_q)
      ST_IDLE, ST_WR, ST_DROP: begin
        if (start_s) begin
          size_d = iwsize;
          tag_d  = itag;
          // A sop inside a running frame aborts it.
          oerr_d = (state_q == ST_WR);
        end else begin
          size_d = size_q;
          tag_d  = tag_q;
        end
        if (push_s) begin
          if (is_last_s) begin
            // Missing eop on the last word: complete, flag, then drop the tail.
            state_d = ST_DONE;
            err_d   = ~ieop;
            drop_d  = ~ieop;
            addr_d  = cADDR_ZERO;
          end else if (ieop) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            drop_d  = 1'b0;
            addr_d  = cADDR_ZERO;
          end else begin
            state_d = ST_WR;
            addr_d  = pack_done_s ? (addr_eff_s + cADDR_ONE) : addr_eff_s;
          end
        end else if (acc_s & ieop & (state_q == ST_DROP)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        owfull_d = 1'b1;
        oerr_d   = err_q;
        owtag_d  = tag_q;
        err_d    = 1'b0;
        drop_d   = 1'b0;
        state_d  = drop_q ? ST_DROP : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and frame registers; everything holds while iclkena is low.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q  <= ST_IDLE;
      size_q   <= cADDR_ZERO;
      addr_q   <= cADDR_ZERO;
      tag_q    <= {pTAG_W{1'b0}};
      owtag_q  <= {pTAG_W{1'b0}};
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      owfull_q <= 1'b0;
      oerr_q   <= 1'b0;
    end else if (iclkena) begin
      state_q  <= state_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      owtag_q  <= owtag_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      owfull_q <= owfull_d;
      oerr_q   <= oerr_d;
    end
  end

  ldpc_dvb_dec_source_pack #(
    .pWADDR_W (pWADDR_W),
    .pWDAT_W  (pWDAT_W),
    .pDAT_W   (pDAT_W)
  ) u_pack (
    .clk_i       (iclk),
    .reset_i     (ireset),
    .clkena_i    (iclkena),
    .push_i      (push_s),
    .restart_i   (start_s),
    .flush_i     (flush_s),
    .dat_i       (idat),
    .addr_i      (addr_eff_s),
    .pack_done_o (pack_done_s),
    .write_o     (owrite),
    .waddr_o     (owaddr),
    .wdat_o      (owdat)
  );

  assign owfull = owfull_q;
  assign oerr   = oerr_q;
  assign owtag  = owtag_q;

endmodule

// File: tb/tb_ldpc_dvb_dec_source.sv
// Directed bench for ldpc_dvb_dec_source (pDAT_W=2, pWDAT_W=8, pWADDR_W=8).
module tb_ldpc_dvb_dec_source;

  logic       clk = 1'b0;
  logic       ireset, iclkena, isop, ieop, ival, iwempty;
  logic [7:0] iwsize;
  logic [1:0] idat;
  logic [3:0] itag;
  logic       ordy, owrite, owfull, oerr;
  logic [7:0] owaddr, owdat;
  logic [3:0] owtag;

  int n_vec = 0;
  int n_miss = 0;
  int pcnt = 0;
  int cyc = 0;
  int last_acc = 0;
  bit en_edge = 1'b0;
  bit bp_mode = 1'b0;
  bit gap_mode = 1'b0;

  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [3:0] fl_tag[$];
  int         fl_cyc[$];
  int         er_cyc[$];

  ldpc_dvb_dec_source dut (
    .iclk(clk), .ireset(ireset), .iclkena(iclkena), .iwsize(iwsize),
    .isop(isop), .ieop(ieop), .ival(ival), .idat(idat), .itag(itag),
    .ordy(ordy), .iwempty(iwempty), .owrite(owrite), .owaddr(owaddr),
    .owdat(owdat), .owtag(owtag), .owfull(owfull), .oerr(oerr)
  );

  always #5 clk = ~clk;

  // Edge counter and whether the last edge actually clocked the DUT.
  always @(posedge clk) begin
    pcnt    <= pcnt + 1;
    en_edge <= iclkena;
  end

  // Log each newly registered write / full / error strobe.
  always @(negedge clk) begin
    if (en_edge) begin
      if (owrite) begin
        wr_a.push_back(owaddr);
        wr_d.push_back(owdat);
      end
      if (owfull) begin
        fl_tag.push_back(owtag);
        fl_cyc.push_back(pcnt);
      end
      if (oerr) er_cyc.push_back(pcnt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_mode();
    cyc++;
    iwempty = bp_mode ? (((cyc / 3) % 2) == 0) : 1'b1;
    iclkena = gap_mode ? cyc[0] : 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply_mode();
      ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    end
  endtask

  task automatic clear_logs();
    @(posedge clk);
    #1;
    wr_a.delete(); wr_d.delete(); fl_tag.delete(); fl_cyc.delete(); er_cyc.delete();
  endtask

  task automatic send(input logic [1:0] d, input logic s, input logic e);
    bit got = 1'b0;
    for (int g = 0; g < 40 && !got; g++) begin
      @(negedge clk);
      apply_mode();
      ival = 1'b1; idat = d; isop = s; ieop = e;
      #1;
      if (bp_mode) chk("ordy_follows_iwempty", ordy, iwempty);
      got = ordy & iclkena;
      @(posedge clk);
      #1;
    end
    last_acc = pcnt;
    n_vec++;
    assert (got) else begin
      n_miss++;
      $error("FAIL accept_timeout observed=no_accept expected=accept");
    end
  endtask

  // Frame of n words with idat = i mod 4, sop on the first word.
  task automatic frame_seq(input logic [3:0] tag, input logic [7:0] size, input int n,
                           input bit eop_last);
    itag = tag; iwsize = size;
    for (int i = 0; i < n; i++)
      send(2'(i % 4), (i == 0), eop_last && (i == n - 1));
  endtask

  task automatic chk_wr(input int i, input logic [7:0] a, input logic [7:0] d);
    if (i < wr_a.size()) begin
      chk($sformatf("wr%0d_addr", i), wr_a[i], a);
      chk($sformatf("wr%0d_data", i), wr_d[i], d);
    end
  endtask

  initial begin
    ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    idat = 2'd0; itag = 4'd0; iwsize = 8'd4; iwempty = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    chk("rst_owrite", owrite, 1'b0);
    chk("rst_owfull", owfull, 1'b0);
    chk("rst_oerr", oerr, 1'b0);
    chk("rst_owaddr", owaddr, 8'h00);
    chk("rst_owdat", owdat, 8'h00);
    chk("rst_owtag", owtag, 4'h0);
    chk("rst_ordy", ordy, 1'b1);
    ireset = 1'b0;
    idle(2);
    clear_logs();

    // 1: normal frame, 16 words, size 4, tag 5
    frame_seq(4'd5, 8'd4, 16, 1'b1);
    @(negedge clk); apply_mode(); ival = 1'b0; #1;
    chk("ordy_in_done", ordy, 1'b0);
    @(negedge clk); apply_mode(); #1;
    chk("owfull_strobe", owfull, 1'b1);
    chk("owtag_at_full", owtag, 4'd5);
    chk("ordy_at_full", ordy, 1'b0);
    @(negedge clk); apply_mode(); #1;
    chk("owfull_one_cycle", owfull, 1'b0);
    chk("ordy_back", ordy, 1'b1);
    idle(3);
    chk("n1_writes", wr_a.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr(i, 8'(i), 8'hE4);
    chk("n1_full", fl_tag.size(), 1);
    if (fl_tag.size() > 0) begin
      chk("n1_full_latency", fl_cyc[0], last_acc + 1);
      chk("n1_tag", fl_tag[0], 4'd5);
    end
    chk("n1_err", er_cyc.size(), 0);
    clear_logs();

    // 2: backpressure, same frame with tag 3
    bp_mode = 1'b1;
    frame_seq(4'd3, 8'd4, 16, 1'b1);
    bp_mode = 1'b0;
    idle(6);
    chk("bp_writes", wr_a.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr(i, 8'(i), 8'hE4);
    chk("bp_full", fl_tag.size(), 1);
    if (fl_tag.size() > 0) chk("bp_tag", fl_tag[0], 4'd3);
    chk("bp_err", er_cyc.size(), 0);
    clear_logs();

    // 3: early eop on word 6 of a size-4 frame
    frame_seq(4'd7, 8'd4, 6, 1'b1);
    idle(6);
    chk("early_writes", wr_a.size(), 2);
    chk_wr(0, 8'h00, 8'hE4);
    chk_wr(1, 8'h01, 8'h04);
    chk("early_full", fl_tag.size(), 1);
    chk("early_err", er_cyc.size(), 1);
    if (fl_tag.size() > 0 && er_cyc.size() > 0) begin
      chk("early_err_with_full", er_cyc[0], fl_cyc[0]);
      chk("early_tag", fl_tag[0], 4'd7);
    end
    clear_logs();

    // 4: late eop (size 2, eop on word 12), then a 1-word-size frame
    frame_seq(4'd10, 8'd2, 12, 1'b1);
    idle(3);
    itag = 4'd2; iwsize = 8'd1;
    send(2'd3, 1'b1, 1'b0);
    send(2'd2, 1'b0, 1'b0);
    send(2'd1, 1'b0, 1'b0);
    send(2'd0, 1'b0, 1'b1);
    idle(6);
    chk("late_writes", wr_a.size(), 3);
    chk_wr(0, 8'h00, 8'hE4);
    chk_wr(1, 8'h01, 8'hE4);
    chk_wr(2, 8'h00, 8'h1B);
    chk("late_full", fl_tag.size(), 2);
    chk("late_err", er_cyc.size(), 1);
    if (fl_tag.size() > 1 && er_cyc.size() > 0) begin
      chk("late_tag0", fl_tag[0], 4'd10);
      chk("late_tag1", fl_tag[1], 4'd2);
      chk("late_err_with_full", er_cyc[0], fl_cyc[0]);
    end
    clear_logs();

    // 5: sop again at word 6 with tag 9
    frame_seq(4'd4, 8'd4, 5, 1'b0);
    frame_seq(4'd9, 8'd4, 16, 1'b1);
    idle(6);
    chk("mid_writes", wr_a.size(), 5);
    chk_wr(0, 8'h00, 8'hE4);
    for (int i = 0; i < 4; i++) chk_wr(i + 1, 8'(i), 8'hE4);
    chk("mid_full", fl_tag.size(), 1);
    if (fl_tag.size() > 0) chk("mid_tag", fl_tag[0], 4'd9);
    chk("mid_err", er_cyc.size(), 1);
    clear_logs();

    // 6: iclkena low on alternate cycles
    gap_mode = 1'b1;
    frame_seq(4'd11, 8'd4, 16, 1'b1);
    idle(10);
    gap_mode = 1'b0;
    idle(2);
    chk("gap_writes", wr_a.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr(i, 8'(i), 8'hE4);
    chk("gap_full", fl_tag.size(), 1);
    if (fl_tag.size() > 0) chk("gap_tag", fl_tag[0], 4'd11);
    chk("gap_err", er_cyc.size(), 0);
    clear_logs();

    // 7: reset after word 5, then a normal size-2 frame
    frame_seq(4'd12, 8'd4, 5, 1'b0);
    @(negedge clk); apply_mode(); ival = 1'b0; isop = 1'b0; ieop = 1'b0; ireset = 1'b1;
    @(negedge clk); #1;
    chk("mrst_owrite", owrite, 1'b0);
    chk("mrst_owfull", owfull, 1'b0);
    chk("mrst_oerr", oerr, 1'b0);
    chk("mrst_owaddr", owaddr, 8'h00);
    chk("mrst_owdat", owdat, 8'h00);
    chk("mrst_owtag", owtag, 4'h0);
    ireset = 1'b0;
    idle(4);
    chk("mrst_writes", wr_a.size(), 1);
    chk("mrst_full", fl_tag.size(), 0);
    clear_logs();
    frame_seq(4'd13, 8'd2, 8, 1'b1);
    idle(6);
    chk("post_writes", wr_a.size(), 2);
    chk_wr(0, 8'h00, 8'hE4);
    chk_wr(1, 8'h01, 8'hE4);
    chk("post_full", fl_tag.size(), 1);
    if (fl_tag.size() > 0) chk("post_tag", fl_tag[0], 4'd13);
    chk("post_err", er_cyc.size(), 0);
    clear_logs();

    // 8: single word with sop and eop (early eop, zero-padded)
    itag = 4'd6; iwsize = 8'd4;
    send(2'd2, 1'b1, 1'b1);
    idle(6);
    chk("one_writes", wr_a.size(), 1);
    chk_wr(0, 8'h00, 8'h02);
    chk("one_full", fl_tag.size(), 1);
    chk("one_err", er_cyc.size(), 1);
    if (fl_tag.size() > 0) chk("one_tag", fl_tag[0], 4'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
